// File: rtl/tristate_bus_arbiter_pkg.sv
// rtl/tristate_bus_arbiter_pkg.sv - shared state encodings and parameter defaults
package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_TURN  = 2'b10
  } state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner search starting after last_owner
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_owner,
  output logic         any,
  output logic [W-1:0] winner
);

  int idx;

  // Walk from the farthest offset to the nearest so the nearest set bit wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = N; i >= 1; i--) begin
      idx = int'(last_owner) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        any    = 1'b1;
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin owner select for a shared tri-state bus
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int W        = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] oe,
  output logic [W-1:0] grant_id,
  output logic         bus_busy,
  output logic         timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   oe_q, oe_d;
  logic [W-1:0]   gid_q, gid_d;
  logic [W-1:0]   last_q, last_d;
  logic [7:0]     hold_q, hold_d;
  logic           busy_q, busy_d;
  logic           tmo_q, tmo_d;
  logic           pick_any;
  logic [W-1:0]   pick_w;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .any        (pick_any),
    .winner     (pick_w)
  );

  always_comb begin
    state_d = state_q;
    oe_d    = '0;
    gid_d   = gid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    busy_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_GRANT: begin
        if (!req[gid_q]) begin
          state_d = ST_TURN;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_TURN;
          hold_d  = '0;
          tmo_d   = 1'b1;
        end else begin
          hold_d  = hold_q + 8'd1;
          oe_d    = oe_q;
          busy_d  = 1'b1;
        end
      end
      // IDLE and TURN leave identically; TURN simply guarantees one all-off cycle.
      default: begin
        if (pick_any) begin
          state_d        = ST_GRANT;
          gid_d          = pick_w;
          last_d         = pick_w;
          oe_d[pick_w]   = 1'b1;
          busy_d         = 1'b1;
          hold_d         = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      oe_q    <= '0;
      gid_q   <= '0;
      last_q  <= W'(N - 1);
      hold_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_q    <= oe_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign oe       = oe_q;
  assign grant_id = gid_q;
  assign bus_busy = busy_q;
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - scenario and randomized checks against a behavioural owner model
module tb_tristate_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] oe;
  logic [1:0]   grant_id;
  logic         bus_busy;
  logic         timeout;

  int vectors;
  int miscompares;

  // Model: current owner (-1 = nobody), cycles it has driven, last winner.
  int           m_owner;
  int           m_cycles;
  int           m_last;
  logic         m_tmo;
  logic [1:0]   m_gid;
  logic [N-1:0] exp_oe;

  tristate_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .oe       (oe),
    .grant_id (grant_id),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input logic [N-1:0] r, input logic rr);
    if (rr) begin
      m_owner = -1; m_cycles = 0; m_last = N - 1; m_tmo = 1'b0; m_gid = 2'd0;
    end else if (m_owner >= 0) begin
      m_tmo = 1'b0;
      if (!r[m_owner]) m_owner = -1;
      else if (m_cycles == MAX_HOLD) begin
        m_owner = -1; m_tmo = 1'b1;
      end else m_cycles++;
    end else begin
      m_tmo = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && r[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      if (m_owner >= 0) begin
        m_cycles = 1; m_last = m_owner; m_gid = 2'(m_owner);
      end
    end
    exp_oe = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
  endtask

  // Apply one cycle of stimulus at the falling edge, update the model at the
  // rising edge, and return at the next falling edge ready for sampling.
  task automatic step(input logic [N-1:0] r, input logic rr);
    req = r; rst = rr;
    @(posedge clk);
    model_step(r, rr);
    @(negedge clk);
  endtask

  task automatic test_reset;
    step('1, 1'b1);
    step('1, 1'b1);
    vectors++;
    if (oe !== '0 || bus_busy !== 1'b0 || timeout !== 1'b0 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset: oe=%b busy=%b tmo=%b gid=%0d, expected all zero", oe, bus_busy, timeout, grant_id);
    end
  endtask

  task automatic test_hold_timeout;
    int tmo_at;
    step('0, 1'b1);
    tmo_at = -1;
    for (int c = 0; c < 12; c++) begin
      step(4'b0101, 1'b0);
      vectors++;
      if (oe !== exp_oe || bus_busy !== (m_owner >= 0) || timeout !== m_tmo) begin
        miscompares++;
        $display("FAIL hold_timeout c%0d: oe=%b busy=%b tmo=%b, expected oe=%b busy=%b tmo=%b",
                 c, oe, bus_busy, timeout, exp_oe, m_owner >= 0, m_tmo);
      end
      if (c == 0) begin
        vectors++;
        if (oe !== 4'b0001 || grant_id !== 2'd0) begin
          miscompares++;
          $display("FAIL hold_first_grant: oe=%b gid=%0d, expected 0001 gid 0", oe, grant_id);
        end
      end
      if (c == 9) begin
        vectors++;
        if (oe !== 4'b0100 || grant_id !== 2'd2) begin
          miscompares++;
          $display("FAIL hold_second_grant: oe=%b gid=%0d, expected 0100 gid 2", oe, grant_id);
        end
      end
      if (timeout === 1'b1 && tmo_at < 0) tmo_at = c;
    end
    vectors++;
    if (tmo_at !== 8) begin
      miscompares++;
      $display("FAIL hold_timeout_cycle: first pulse at %0d, expected 8", tmo_at);
    end
  endtask

  task automatic test_single_requester;
    int n_tmo;
    int n_drive;
    step('0, 1'b1);
    n_tmo = 0; n_drive = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b1000, 1'b0);
      vectors++;
      if (oe !== exp_oe || timeout !== m_tmo) begin
        miscompares++;
        $display("FAIL single c%0d: oe=%b tmo=%b, expected oe=%b tmo=%b", c, oe, timeout, exp_oe, m_tmo);
      end
      if (timeout === 1'b1) n_tmo++;
      if (oe === 4'b1000) n_drive++;
    end
    vectors++;
    if (n_tmo !== 2 || n_drive !== 18) begin
      miscompares++;
      $display("FAIL single_counts: timeouts=%0d drive=%0d, expected 2 and 18", n_tmo, n_drive);
    end
  endtask

  task automatic test_release;
    int n_drive;
    int n_tmo;
    step('0, 1'b1);
    n_drive = 0; n_tmo = 0;
    for (int c = 0; c < 7; c++) begin
      step((c < 3) ? 4'b0010 : 4'b0000, 1'b0);
      if (oe === 4'b0010) n_drive++;
      if (timeout === 1'b1) n_tmo++;
    end
    vectors++;
    if (n_drive !== 3 || n_tmo !== 0 || bus_busy !== 1'b0 || oe !== '0) begin
      miscompares++;
      $display("FAIL release: drive=%0d tmo=%0d busy=%b oe=%b, expected 3 0 0 0000",
               n_drive, n_tmo, bus_busy, oe);
    end
  endtask

  task automatic test_all_round_robin;
    int seq[$];
    logic prev_busy;
    step('0, 1'b1);
    prev_busy = 1'b0;
    for (int c = 0; c < 45; c++) begin
      step(4'b1111, 1'b0);
      vectors++;
      if ($countones(oe) > 1 || oe !== exp_oe) begin
        miscompares++;
        $display("FAIL all_rr c%0d: oe=%b, expected %b", c, oe, exp_oe);
      end
      if (bus_busy === 1'b1 && prev_busy === 1'b0) seq.push_back(int'(grant_id));
      prev_busy = bus_busy;
    end
    vectors++;
    if (seq.size() < 5 || seq[0] != 0 || seq[1] != 1 || seq[2] != 2 || seq[3] != 3 || seq[4] != 0) begin
      miscompares++;
      $display("FAIL all_rr_order: got %p, expected 0,1,2,3,0", seq);
    end
  endtask

  task automatic test_reset_mid_grant;
    bit found;
    step('0, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step(4'b1111, 1'b0);
      if (bus_busy === 1'b1 && grant_id === 2'd2) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_mid_wait: owner 2 never granted within 40 cycles");
    end
    step(4'b1111, 1'b1);
    vectors++;
    if (oe !== '0 || bus_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_drop: oe=%b busy=%b, expected 0000 0", oe, bus_busy);
    end
    step(4'b1111, 1'b0);
    vectors++;
    if (oe !== 4'b0001 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_restart: oe=%b gid=%0d, expected 0001 gid 0", oe, grant_id);
    end
  endtask

  task automatic test_nonowner_toggle;
    int n_drive;
    step('0, 1'b1);
    n_drive = 0;
    for (int c = 0; c < 10; c++) begin
      step((c % 2 == 1) ? 4'b1010 : 4'b0010, 1'b0);
      vectors++;
      if (oe !== exp_oe) begin
        miscompares++;
        $display("FAIL toggle c%0d: oe=%b, expected %b", c, oe, exp_oe);
      end
      if (oe === 4'b0010) n_drive++;
    end
    vectors++;
    if (n_drive !== MAX_HOLD) begin
      miscompares++;
      $display("FAIL toggle_hold: owner 1 drove %0d cycles, expected %0d", n_drive, MAX_HOLD);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] r;
    logic rr;
    step('0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      r  = N'($urandom);
      if ($urandom_range(3, 0) == 0) r = '1;
      rr = ($urandom_range(39, 0) == 0);
      step(r, rr);
      vectors++;
      if (oe !== exp_oe || bus_busy !== (m_owner >= 0) || timeout !== m_tmo ||
          (m_owner >= 0 && grant_id !== m_gid)) begin
        miscompares++;
        $display("FAIL random c%0d req=%b rst=%b: oe=%b busy=%b tmo=%b gid=%0d, expected oe=%b busy=%b tmo=%b gid=%0d",
                 c, r, rr, oe, bus_busy, timeout, grant_id, exp_oe, m_owner >= 0, m_tmo, m_gid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0;
    req = '0; rst = 1'b1;
    m_owner = -1; m_cycles = 0; m_last = N - 1; m_tmo = 1'b0; m_gid = 2'd0; exp_oe = '0;
    @(negedge clk);
    test_reset();
    test_hold_timeout();
    test_single_requester();
    test_release();
    test_all_round_robin();
    test_reset_mid_grant();
    test_nonowner_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
